// File: rtl/l1_ahb_mtx_in_stg.sv
// Purpose : AHB bus-matrix input stage; decodes each address phase to output port 0/1 and requests it.
// Latency : live issue adds 0 cycles; a blocked transfer is held and issued on the first grant+ready cycle.
// Backpress: wait-states the master (HREADYOUTS=0) while a transfer is held; unmapped -> 2-cycle ERROR.
//
// Ports:
//   HCLK, HRESETn                       clock, async active-low reset
//   HSELS/HADDRS/HTRANSS/HWRITES/...    master-side address phase, HREADYS = bus HREADY
//   HREADYOUTS/HRESPS                   response to master
//   req_port/sel_port                   request / one-hot target per output port
//   HADDRI..HMASTLOCKI                  address phase forwarded to output stages
//   active_port/HREADYM/HRESPM          grant and data-phase response from each output port
module l1_ahb_mtx_in_stg #(
    parameter logic [2:0] P0_REGION = 3'b000,
    parameter logic [2:0] P1_REGION = 3'b001
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic [2:0]  HBURSTS,
    input  logic [3:0]  HPROTS,
    input  logic        HMASTLOCKS,
    input  logic        HREADYS,
    output logic        HREADYOUTS,
    output logic        HRESPS,
    output logic [1:0]  req_port,
    output logic [1:0]  sel_port,
    output logic [31:0] HADDRI,
    output logic [1:0]  HTRANSI,
    output logic        HWRITEI,
    output logic [2:0]  HSIZEI,
    output logic [2:0]  HBURSTI,
    output logic [3:0]  HPROTI,
    output logic        HMASTLOCKI,
    input  logic [1:0]  active_port,
    input  logic [1:0]  HREADYM,
    input  logic [1:0]  HRESPM
);

    typedef enum logic [2:0] {
        DPH_NONE,
        DPH_P0,
        DPH_P1,
        DPH_ERR1,
        DPH_ERR2
    } dph_t;

    dph_t        r_dph;
    dph_t        w_dph_nxt;

    logic        r_pend;
    logic        r_tgt;
    logic [31:0] r_addr;
    logic [1:0]  r_trans;
    logic        r_write;
    logic [2:0]  r_size;
    logic [2:0]  r_burst;
    logic [3:0]  r_prot;
    logic        r_lock;

    logic        w_accept;
    logic        w_acc_new;
    logic        w_dec0;
    logic        w_dec1;
    logic        w_mapped;
    logic        w_tgt;
    logic        w_live_issue;
    logic        w_hold;
    logic        w_err_acc;
    logic        w_held_issue;

    assign w_accept  = HSELS & HREADYS & HTRANSS[1];
    // A new accept while a transfer is held is a master protocol violation; it is ignored.
    assign w_acc_new = w_accept & ~r_pend;

    // Port 0 wins if both regions are configured identically.
    assign w_dec0   = (HADDRS[31:29] == P0_REGION);
    assign w_dec1   = ~w_dec0 & (HADDRS[31:29] == P1_REGION);
    assign w_mapped = w_dec0 | w_dec1;
    assign w_tgt    = w_dec1;

    assign w_live_issue = w_acc_new & w_mapped & active_port[w_tgt] & HREADYM[w_tgt];
    assign w_hold       = w_acc_new & w_mapped & ~w_live_issue;
    assign w_err_acc    = w_acc_new & ~w_mapped;
    assign w_held_issue = r_pend & active_port[r_tgt] & HREADYM[r_tgt];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend <= 1'b0;
            r_tgt  <= 1'b0;
        end else if (w_held_issue) begin
            r_pend <= 1'b0;
        end else if (w_hold) begin
            r_pend <= 1'b1;
            r_tgt  <= w_tgt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_trans <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
            r_lock  <= 1'b0;
        end else if (w_hold) begin
            r_addr  <= HADDRS;
            r_trans <= HTRANSS;
            r_write <= HWRITES;
            r_size  <= HSIZES;
            r_burst <= HBURSTS;
            r_prot  <= HPROTS;
            r_lock  <= HMASTLOCKS;
        end
    end

    // Output mux: held transfer has priority over the live bus.
    assign HADDRI     = r_pend ? r_addr  : HADDRS;
    assign HTRANSI    = r_pend ? r_trans : HTRANSS;
    assign HWRITEI    = r_pend ? r_write : HWRITES;
    assign HSIZEI     = r_pend ? r_size  : HSIZES;
    assign HBURSTI    = r_pend ? r_burst : HBURSTS;
    assign HPROTI     = r_pend ? r_prot  : HPROTS;
    assign HMASTLOCKI = r_pend ? r_lock  : HMASTLOCKS;

    assign sel_port[0] = r_pend ? ~r_tgt : (HSELS & w_dec0);
    assign sel_port[1] = r_pend ?  r_tgt : (HSELS & w_dec1);
    assign req_port[0] = (r_pend & ~r_tgt) | (w_acc_new & w_dec0);
    assign req_port[1] = (r_pend &  r_tgt) | (w_acc_new & w_dec1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dph <= DPH_NONE;
        end else begin
            r_dph <= w_dph_nxt;
        end
    end

    // ERR1 always advances (master is stalled); a held issue advances even though HREADYS is low.
    always_comb begin
        w_dph_nxt = r_dph;
        if (r_dph == DPH_ERR1) begin
            w_dph_nxt = DPH_ERR2;
        end else if (w_held_issue) begin
            w_dph_nxt = r_tgt ? DPH_P1 : DPH_P0;
        end else if (HREADYS) begin
            if (w_live_issue) begin
                w_dph_nxt = w_tgt ? DPH_P1 : DPH_P0;
            end else if (w_err_acc) begin
                w_dph_nxt = DPH_ERR1;
            end else begin
                w_dph_nxt = DPH_NONE;
            end
        end else if (r_dph == DPH_ERR2) begin
            w_dph_nxt = DPH_NONE;
        end
    end

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        if (r_pend) begin
            HREADYOUTS = 1'b0;
            HRESPS     = 1'b0;
        end else begin
            case (r_dph)
                DPH_P0: begin
                    HREADYOUTS = HREADYM[0];
                    HRESPS     = HRESPM[0];
                end
                DPH_P1: begin
                    HREADYOUTS = HREADYM[1];
                    HRESPS     = HRESPM[1];
                end
                DPH_ERR1: begin
                    HREADYOUTS = 1'b0;
                    HRESPS     = 1'b1;
                end
                DPH_ERR2: begin
                    HREADYOUTS = 1'b1;
                    HRESPS     = 1'b1;
                end
                default: begin
                    HREADYOUTS = 1'b1;
                    HRESPS     = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_ahb_mtx_in_stg.sv
// Purpose : scoreboard bench for the AHB matrix input stage; directed cycle vectors.
// Latency : expected outputs are tagged with the cycle they must appear in.
// Backpress: HREADYS is driven to mirror the expected HREADYOUTS of each cycle.
module tb_l1_ahb_mtx_in_stg;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSELS = 1'b0;
    logic [31:0] HADDRS = '0;
    logic [1:0]  HTRANSS = '0;
    logic        HWRITES = 1'b0;
    logic [2:0]  HSIZES = 3'b010;
    logic [2:0]  HBURSTS = '0;
    logic [3:0]  HPROTS = 4'b0011;
    logic        HMASTLOCKS = 1'b0;
    logic        HREADYS = 1'b1;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic [1:0]  req_port;
    logic [1:0]  sel_port;
    logic [31:0] HADDRI;
    logic [1:0]  HTRANSI;
    logic        HWRITEI;
    logic [2:0]  HSIZEI;
    logic [2:0]  HBURSTI;
    logic [3:0]  HPROTI;
    logic        HMASTLOCKI;
    logic [1:0]  active_port = '0;
    logic [1:0]  HREADYM = 2'b11;
    logic [1:0]  HRESPM = '0;

    l1_ahb_mtx_in_stg dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .req_port(req_port),
        .sel_port(sel_port), .HADDRI(HADDRI), .HTRANSI(HTRANSI), .HWRITEI(HWRITEI),
        .HSIZEI(HSIZEI), .HBURSTI(HBURSTI), .HPROTI(HPROTI), .HMASTLOCKI(HMASTLOCKI),
        .active_port(active_port), .HREADYM(HREADYM), .HRESPM(HRESPM)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        int          cyc;
        logic [1:0]  req;
        logic [1:0]  sel;
        logic        rdy;
        logic        resp;
        logic        chk_a;
        logic [31:0] addr;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NSEQ = 2'b10;

    task automatic drive(input logic s, input logic [31:0] a, input logic [1:0] t,
                         input logic w, input logic [1:0] act, input logic [1:0] hrm,
                         input logic [1:0] hrp, input logic rs);
        HSELS       = s;
        HADDRS      = a;
        HTRANSS     = t;
        HWRITES     = w;
        active_port = act;
        HREADYM     = hrm;
        HRESPM      = hrp;
        HREADYS     = rs;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] req, input logic [1:0] sel,
                              input logic rdy, input logic resp, input logic ca,
                              input logic [31:0] addr);
        exp_t e;
        e.cyc   = cyc;
        e.req   = req;
        e.sel   = sel;
        e.rdy   = rdy;
        e.resp  = resp;
        e.chk_a = ca;
        e.addr  = addr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic next_cyc();
        @(posedge HCLK);
        #1;
    endtask

    // Monitor: compares every expectation tagged for the current cycle, mid-cycle.
    always @(negedge HCLK) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            exp_t  e;
            string nm;
            logic  bad;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks = checks + 1;
            bad = (e.cyc != cyc) || (req_port !== e.req) || (sel_port !== e.sel) ||
                  (HREADYOUTS !== e.rdy) || (HRESPS !== e.resp) ||
                  (e.chk_a && (HADDRI !== e.addr));
            if (bad) begin
                failures = failures + 1;
                $display("FAIL %s (cyc %0d/%0d): got req=%b sel=%b rdy=%b resp=%b addr=%h, expected req=%b sel=%b rdy=%b resp=%b addr=%h",
                         nm, cyc, e.cyc, req_port, sel_port, HREADYOUTS, HRESPS, HADDRI,
                         e.req, e.sel, e.rdy, e.resp, e.addr);
            end
        end
    end

    initial begin
        //            sel   addr           trans wr   act    hrm    hrp    hreadys
        next_cyc(); drive(1'b0, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
        expect_out("reset_idle",      2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cyc(); drive(1'b1, 32'h2000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
        expect_out("reset_sel_live",  2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 32'h2000_0000);

        // Live issue to port 0
        next_cyc(); HRESETn = 1'b1;
        drive(1'b1, 32'h0000_0010, NSEQ, 1'b0, 2'b01, 2'b11, 2'b00, 1'b1);
        expect_out("live_req",        2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 32'h0000_0010);
        next_cyc(); drive(1'b1, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0);
        expect_out("live_dph_wait",   2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0);
        next_cyc(); drive(1'b0, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
        expect_out("live_dph_done",   2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);

        // Hold: port 1 not granted
        next_cyc(); drive(1'b1, 32'h2000_0004, NSEQ, 1'b1, 2'b00, 2'b11, 2'b00, 1'b1);
        expect_out("hold_accept",     2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 32'h2000_0004);
        next_cyc(); drive(1'b1, 32'h0000_0020, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
        expect_out("hold_pend1",      2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 32'h2000_0004);
        // Accept while pending (protocol violation) must be ignored even if it could issue live
        next_cyc(); drive(1'b1, 32'h0000_0030, NSEQ, 1'b0, 2'b01, 2'b11, 2'b00, 1'b1);
        expect_out("hold_ignore_acc", 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 32'h2000_0004);
        next_cyc(); drive(1'b1, 32'h4000_0000, IDLE, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0);
        expect_out("hold_grant_nrdy", 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 32'h2000_0004);
        next_cyc(); drive(1'b1, 32'h4000_0000, IDLE, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0);
        expect_out("hold_issue",      2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 32'h2000_0004);
        next_cyc(); drive(1'b0, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b10, 2'b01, 1'b1);
        expect_out("hold_dph_p1",     2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0000_0000);

        // Unmapped -> two-cycle ERROR
        next_cyc(); drive(1'b1, 32'hE000_0000, NSEQ, 1'b0, 2'b11, 2'b11, 2'b00, 1'b1);
        expect_out("unmap_accept",    2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cyc(); drive(1'b0, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
        expect_out("unmap_err1",      2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        next_cyc(); drive(1'b0, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
        expect_out("unmap_err2",      2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0);

        // IDLE with HSELS
        next_cyc(); drive(1'b1, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
        expect_out("idle_sel",        2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0);

        // Reset mid-hold
        next_cyc(); drive(1'b1, 32'h0000_0100, NSEQ, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
        expect_out("rst_hold_acc",    2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        next_cyc(); drive(1'b0, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
        expect_out("rst_hold_pend",   2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        next_cyc(); HRESETn = 1'b0;
        drive(1'b0, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
        expect_out("rst_mid_hold",    2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0000_0000);
        next_cyc(); HRESETn = 1'b1;
        drive(1'b1, 32'h2000_0008, NSEQ, 1'b0, 2'b10, 2'b11, 2'b00, 1'b1);
        expect_out("post_rst_live",   2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 32'h2000_0008);
        next_cyc(); drive(1'b0, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b10, 1'b1);
        expect_out("post_rst_dph",    2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0);
        next_cyc(); drive(1'b0, 32'h0000_0000, IDLE, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
        expect_out("final_idle",      2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge HCLK);
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
